// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to enable the multi-cycle shift-add multiply on opcode 1110.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] out_q;
  logic             carry_q, zero_q, ovf_q, out_valid_q;
  logic             accept, load_alu, idle;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;
  state_e             state_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic               is_mul;

  assign idle     = (state_q == StIdle);
  assign is_mul   = (ctrl == 4'hE);
  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign idle = 1'b1;
`endif

  assign in_ready = idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
`ifdef ALU_MUL_EN
  assign load_alu = accept && !is_mul;
`else
  assign load_alu = accept;
`endif

  always_comb begin
    sum     = {1'b0, x} + {1'b0, y};
    diff    = {1'b0, x} - {1'b0, y};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ctrl)
      4'h0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      4'h1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];  // borrow out of the zero-extended subtraction
        alu_v   = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      4'h2: alu_res = x & y;
      4'h3: alu_res = x | y;
      4'h4: alu_res = ~x;
      4'h5: alu_res = x ^ y;
      4'h6: alu_res = ~(x | y);
      4'h7: alu_res = y << x[SHW-1:0];
      4'h8: alu_res = y >> x[SHW-1:0];
      4'h9: alu_res = {x[WIDTH-1], x[WIDTH-1:1]};
      4'hA: alu_res = {x[WIDTH-2:0], x[WIDTH-1]};
      4'hB: alu_res = {x[0], x[WIDTH-1:1]};
      4'hC: alu_res = {{(WIDTH-1){1'b0}}, (x == y)};
      4'hD: alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= StIdle;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (load_alu) begin
        out_q       <= alu_res;
        carry_q     <= alu_c;
        zero_q      <= (alu_res == '0);
        ovf_q       <= alu_v;
        out_valid_q <= 1'b1;
      end
`ifdef ALU_MUL_EN
      case (state_q)
        StIdle: begin
          if (accept && is_mul) begin
            state_q  <= StMul;
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, x};
            mplier_q <= y;
            cnt_q    <= '0;
          end
        end
        StMul: begin
          prod_q   <= prod_nxt;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;  // wraps back to zero on the last iteration
          if (cnt_q == LastCnt) begin
            state_q     <= StIdle;
            out_q       <= prod_nxt[WIDTH-1:0];
            carry_q     <= |prod_nxt[2*WIDTH-1:WIDTH];
            zero_q      <= (prod_nxt[WIDTH-1:0] == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
`endif
    end
  end

  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule
